// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream between the FFT core and its bit-reversal reorder buffer.
interface fft_bitrev_reorder_if #(
    parameter int DBW = 8
);
    logic               clear;
    logic               sof;
    logic [2*DBW-1:0]   din;
    logic [2*DBW-1:0]   dout;
    logic               dout_valid;
    logic               dout_sof;

    modport master (
        output clear, sof, din,
        input  dout, dout_valid, dout_sof
    );

    modport slave (
        input  clear, sof, din,
        output dout, dout_valid, dout_sof
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames written at bit-reversed addresses in one
// bank while the other bank is streamed out in natural bin order.
module fft_bitrev_reorder #(
    parameter int DBW = 8,
    parameter int CBW = 3
) (
    input  logic              clk,
    input  logic              rstx,
    fft_bitrev_reorder_if.slave bus
);
    localparam int N = 1 << CBW;
    localparam logic [CBW-1:0] LAST = CBW'(N - 1);

    function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] k);
        logic [CBW-1:0] r;
        for (int i = 0; i < CBW; i++) r[i] = k[CBW-1-i];
        return r;
    endfunction

    logic [2*DBW-1:0] mem_q [2*N];

    logic             armed_q, armed_d;
    logic [CBW-1:0]   wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             rd_active_q, rd_active_d;
    logic [CBW-1:0]   rcnt_q, rcnt_d;
    logic [2*DBW-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_sof_q, dout_sof_d;

    logic             wr_en;
    logic [CBW-1:0]   wptr;
    logic             frame_done;
    logic [CBW:0]     waddr;
    logic [CBW:0]     raddr;

    always_comb begin
        // A sof always (re)starts the frame at index 0, in the current bank.
        wr_en      = bus.sof | armed_q;
        wptr       = bus.sof ? '0 : wcnt_q;
        frame_done = wr_en && (wptr == LAST);
        waddr      = {wbank_q, bitrev(wptr)};
        raddr      = {~wbank_q, rcnt_q};

        armed_d      = armed_q;
        wcnt_d       = wcnt_q;
        wbank_d      = wbank_q;
        rd_active_d  = rd_active_q;
        rcnt_d       = rcnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;

        if (bus.clear) begin
            armed_d     = 1'b0;
            wcnt_d      = '0;
            wbank_d     = 1'b0;
            rd_active_d = 1'b0;
            rcnt_d      = '0;
            dout_d      = '0;
        end else begin
            if (wr_en) begin
                armed_d = 1'b1;
                wcnt_d  = wptr + CBW'(1);
            end
            if (rd_active_q) begin
                dout_d       = mem_q[raddr];
                dout_valid_d = 1'b1;
                dout_sof_d   = (rcnt_q == '0);
                rcnt_d       = rcnt_q + CBW'(1);
                if (rcnt_q == LAST) rd_active_d = 1'b0;
            end
            // A completing frame hands its bank to the reader with no gap.
            if (frame_done) begin
                wbank_d     = ~wbank_q;
                rd_active_d = 1'b1;
                rcnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !bus.clear) mem_q[waddr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            armed_q      <= 1'b0;
            wcnt_q       <= '0;
            wbank_q      <= 1'b0;
            rd_active_q  <= 1'b0;
            rcnt_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            wcnt_q       <= wcnt_d;
            wbank_q      <= wbank_d;
            rd_active_q  <= rd_active_d;
            rcnt_q       <= rcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_sof   = dout_sof_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the bit-reversal reorder buffer: directed frames plus random
// traffic, checked every cycle against a frame-level reference model.
module tb_fft_bitrev_reorder;
    localparam int DBW = 8;
    localparam int CBW = 3;
    localparam int N   = 8;
    localparam int SZ  = 4096;

    logic clk = 1'b0;
    logic rstx = 1'b0;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DBW(DBW)) bus();

    fft_bitrev_reorder #(.DBW(DBW), .CBW(CBW)) dut (
        .clk  (clk),
        .rstx (rstx),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected output per model cycle, filled when a frame completes.
    logic        sch_v [SZ];
    logic        sch_s [SZ];
    logic [15:0] sch_d [SZ];
    logic [15:0] frm [$];
    logic        m_armed;
    logic [15:0] m_last;
    logic        e_v, e_s;

    logic [7:0] plan_re [8] = '{8'h00, 8'h40, 8'h20, 8'h60, 8'h10, 8'h50, 8'h30, 8'h70};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < CBW; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    task automatic wipe();
        for (int i = cyc; i < SZ; i++) sch_v[i] = 1'b0;
    endtask

    task automatic model_reset();
        frm.delete();
        m_armed = 1'b0;
        m_last  = '0;
        wipe();
    endtask

    // Frame-level model: collect N samples in arrival order; natural bin m is
    // the sample that arrived at position bitrev(m). Bins come out N cycles on.
    task automatic model_edge(input logic s, input logic c, input logic [15:0] d);
        if (c) begin
            model_reset();
        end else begin
            if (s) begin
                frm.delete();
                frm.push_back(d);
                m_armed = 1'b1;
            end else if (m_armed) begin
                frm.push_back(d);
            end
            if (frm.size() == N) begin
                for (int m = 0; m < N; m++) begin
                    sch_v[cyc+1+m] = 1'b1;
                    sch_s[cyc+1+m] = (m == 0);
                    sch_d[cyc+1+m] = frm[bitrev(m)];
                end
                frm.delete();
            end
        end
        if (!c && sch_v[cyc]) begin
            e_v    = 1'b1;
            e_s    = sch_s[cyc];
            m_last = sch_d[cyc];
        end else begin
            e_v = 1'b0;
            e_s = 1'b0;
        end
    endtask

    task automatic step(input logic s, input logic c, input logic [15:0] d);
        bus.sof   = s;
        bus.clear = c;
        bus.din   = d;
        @(posedge clk);
        model_edge(s, c, d);
        #1;
        chk("dout_valid", 32'(bus.dout_valid), 32'(e_v));
        chk("dout_sof",   32'(bus.dout_sof),   32'(e_s));
        chk("dout",       32'(bus.dout),       32'(m_last));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SZ; i++) sch_v[i] = 1'b0;
        m_armed   = 1'b0;
        m_last    = '0;
        bus.sof   = 1'b0;
        bus.clear = 1'b0;
        bus.din   = '0;
        repeat (3) @(posedge clk);
        #2 rstx = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_sof",   32'(bus.dout_sof),   32'd0);
        chk("rst_dout",  32'(bus.dout),       32'd0);

        // Din before any sof is ignored.
        idle(5);

        // Single frame followed by a back-to-back frame with imag 0x01.
        for (int k = 0; k < N; k++) step(k == 0, 1'b0, {8'h00, plan_re[k]});
        for (int k = 0; k < N; k++) step(1'b0, 1'b0, {8'h01, plan_re[k]});
        idle(N);
        step(1'b0, 1'b1, 16'hdead);
        idle(4);

        // Clear while the first frame is being read out.
        for (int k = 0; k < N; k++) step(k == 0, 1'b0, {8'h02, plan_re[k]});
        idle(2);
        step(1'b0, 1'b1, 16'hbeef);
        idle(12);

        // Clear and sof together: clear wins, nothing follows.
        step(1'b1, 1'b1, 16'h1234);
        idle(12);

        // Resync: second sof three cycles into the frame.
        step(1'b1, 1'b0, 16'h0a0a);
        idle(2);
        for (int k = 0; k < N; k++) step(k == 0, 1'b0, {8'h03, plan_re[k]});
        idle(N + 2);
        step(1'b0, 1'b1, 16'h0);

        // Async reset mid-frame and mid-readout.
        for (int k = 0; k < N; k++) step(k == 0, 1'b0, 16'($urandom));
        idle(3);
        #2 rstx = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.dout_valid), 32'd0);
        chk("arst_sof",   32'(bus.dout_sof),   32'd0);
        chk("arst_dout",  32'(bus.dout),       32'd0);
        model_reset();
        bus.sof = 1'b0;
        bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstx = 1'b1;
        idle(3);
        for (int k = 0; k < N; k++) step(k == 0, 1'b0, 16'($urandom));
        idle(N + 1);
        step(1'b0, 1'b1, 16'h0);

        // Random traffic with occasional sof and clear.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, 16'($urandom));
        idle(2 * N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
